// File: rtl/blur_filter_if.sv
// rtl/blur_filter_if.sv - window-in / pixel-out stream bundle for the blur filter
interface blur_filter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [9*DATA_WIDTH-1:0] i_window;
    logic                    i_window_valid;
    logic                    i_mode;
    logic [DATA_WIDTH-1:0]   o_pixel;
    logic                    o_pixel_valid;
    logic                    o_frame_end;

    modport master (
        output i_window, i_window_valid, i_mode,
        input  o_pixel, o_pixel_valid, o_frame_end
    );

    modport slave (
        input  i_window, i_window_valid, i_mode,
        output o_pixel, o_pixel_valid, o_frame_end
    );
endinterface

// File: rtl/blur_filter.sv
// rtl/blur_filter.sv - 3-stage 3x3 box/Gaussian blur with raster tracking and border pass-through
module blur_filter #(
    parameter int DATA_WIDTH   = 8,
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 512
) (
    input logic          i_clk,
    input logic          i_reset,
    blur_filter_if.slave bus
);
    localparam int CW   = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int RW   = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int WINW = 9 * DATA_WIDTH;

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic                  w_col_last, w_row_last, w_border;

    logic                  r_s1_valid, r_s1_mode, r_s1_border, r_s1_last;
    logic [WINW-1:0]       r_s1_window;
    logic [DATA_WIDTH-1:0] r_s1_centre;

    logic                  r_s2_valid, r_s2_mode, r_s2_border, r_s2_last;
    logic [11:0]           r_s2_sum;
    logic [DATA_WIDTH-1:0] r_s2_centre;

    logic [11:0]           w_box_sum, w_gauss_sum;
    logic [25:0]           w_box_prod;
    logic [9:0]            w_box_q;
    logic [12:0]           w_gauss_rnd;
    logic [8:0]            w_gauss_q;
    logic [9:0]            w_scaled;
    logic [DATA_WIDTH-1:0] w_clamped;

    assign w_col_last = (r_col == CW'(IMAGE_WIDTH - 1));
    assign w_row_last = (r_row == RW'(IMAGE_HEIGHT - 1));
    assign w_border   = (r_col == '0) | w_col_last | (r_row == '0) | w_row_last;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (bus.i_window_valid) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Border windows are zeroed so undefined neighbour bytes never enter the adder tree
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_mode   <= 1'b0;
            r_s1_border <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_window <= '0;
            r_s1_centre <= '0;
        end else begin
            r_s1_valid <= bus.i_window_valid;
            if (bus.i_window_valid) begin
                r_s1_mode   <= bus.i_mode;
                r_s1_border <= w_border;
                r_s1_last   <= w_row_last & w_col_last;
                r_s1_window <= w_border ? '0 : bus.i_window;
                r_s1_centre <= bus.i_window[4*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    function automatic logic [11:0] pix(input logic [WINW-1:0] win, input int n);
        return 12'(win[n*DATA_WIDTH +: DATA_WIDTH]);
    endfunction

    always_comb begin
        w_box_sum = '0;
        for (int n = 0; n < 9; n++) begin
            w_box_sum = w_box_sum + pix(r_s1_window, n);
        end
        w_gauss_sum = pix(r_s1_window, 0) + (pix(r_s1_window, 1) << 1) + pix(r_s1_window, 2)
                    + (pix(r_s1_window, 3) << 1) + (pix(r_s1_window, 4) << 2)
                    + (pix(r_s1_window, 5) << 1) + pix(r_s1_window, 6)
                    + (pix(r_s1_window, 7) << 1) + pix(r_s1_window, 8);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s2_valid  <= 1'b0;
            r_s2_mode   <= 1'b0;
            r_s2_border <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s2_sum    <= '0;
            r_s2_centre <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_mode   <= r_s1_mode;
                r_s2_border <= r_s1_border;
                r_s2_last   <= r_s1_last;
                r_s2_sum    <= r_s1_mode ? w_gauss_sum : w_box_sum;
                r_s2_centre <= r_s1_centre;
            end
        end
    end

    // 7282/65536 approximates 1/9 closely enough to round exactly over the whole box-sum range
    assign w_box_prod  = 26'(r_s2_sum) * 26'd7282 + 26'd32768;
    assign w_box_q     = 10'(w_box_prod >> 16);
    assign w_gauss_rnd = 13'(r_s2_sum) + 13'd8;
    assign w_gauss_q   = 9'(w_gauss_rnd >> 4);
    assign w_scaled    = r_s2_mode ? {1'b0, w_gauss_q} : w_box_q;
    assign w_clamped   = (w_scaled > 10'((1 << DATA_WIDTH) - 1)) ? '1 : DATA_WIDTH'(w_scaled);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bus.o_pixel       <= '0;
            bus.o_pixel_valid <= 1'b0;
            bus.o_frame_end   <= 1'b0;
        end else begin
            bus.o_pixel_valid <= r_s2_valid;
            bus.o_frame_end   <= r_s2_valid & r_s2_last;
            if (r_s2_valid) begin
                bus.o_pixel <= r_s2_border ? r_s2_centre : w_clamped;
            end
        end
    end
endmodule

// File: tb/tb_blur_filter.sv
// tb/tb_blur_filter.sv - scoreboard bench for blur_filter on a 4x4 frame
module tb_blur_filter;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    typedef struct {
        logic [DW-1:0] pix;
        logic          fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    blur_filter_if #(.DATA_WIDTH(DW)) bus();

    blur_filter #(
        .DATA_WIDTH  (DW),
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus.slave)
    );

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;
    int   t_in     = -1;
    int   t_out    = -1;
    int   row_m    = 0;
    int   col_m    = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.o_pixel_valid !== 1'b0) begin
            if (t_out < 0) t_out = cycle;
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: actual pixel %0h required no output (t=%0t)", bus.o_pixel, $time);
            end else begin
                mon_e = q.pop_front();
                check("pixel", 32'(bus.o_pixel), 32'(mon_e.pix));
                check("frame_end", 32'(bus.o_frame_end), 32'(mon_e.fe));
            end
        end else begin
            check("frame_end_idle", 32'(bus.o_frame_end), 32'd0);
        end
    end

    function automatic logic is_border();
        return (row_m == 0) || (row_m == H - 1) || (col_m == 0) || (col_m == W - 1);
    endfunction

    task automatic beat(input logic [9*DW-1:0] win, input logic mode, input logic [DW-1:0] pix);
        exp_t e;
        e.pix = pix;
        e.fe  = (row_m == H - 1) && (col_m == W - 1);
        q.push_back(e);
        if (t_in < 0) t_in = cycle;
        bus.i_window       = win;
        bus.i_mode         = mode;
        bus.i_window_valid = 1'b1;
        if (col_m == W - 1) begin
            col_m = 0;
            row_m = (row_m == H - 1) ? 0 : row_m + 1;
        end else begin
            col_m = col_m + 1;
        end
        @(posedge clk);
        #1;
        bus.i_window_valid = 1'b0;
    endtask

    task automatic bdr(input logic [DW-1:0] c, input logic mode, input logic use_x);
        logic [31:0] side;
        side = use_x ? 32'bx : 32'h0;
        beat({side, c, side}, mode, c);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference arithmetic: plain integer round-to-nearest division
    function automatic logic [DW-1:0] model(input logic [9*DW-1:0] win, input logic mode, input logic border);
        int w[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        int s = 0;
        if (border) return win[4*DW +: DW];
        for (int n = 0; n < 9; n++) s += (mode ? w[n] : 1) * int'(win[n*DW +: DW]);
        return mode ? DW'((s + 8) / 16) : DW'((s + 4) / 9);
    endfunction

    task automatic mbeat(input logic [9*DW-1:0] win, input logic mode);
        beat(win, mode, model(win, mode, is_border()));
    endtask

    function automatic logic [9*DW-1:0] gen_win(input int seed);
        logic [9*DW-1:0] w;
        for (int n = 0; n < 9; n++) w[n*DW +: DW] = DW'(seed * 37 + n * 11 + 5);
        return w;
    endfunction

    initial begin
        bus.i_window       = '0;
        bus.i_window_valid = 1'b0;
        bus.i_mode         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        repeat (5) begin
            @(negedge clk);
            check("idle_valid", 32'(bus.o_pixel_valid), 32'd0);
            check("idle_pixel", 32'(bus.o_pixel), 32'd0);
            check("idle_frame_end", 32'(bus.o_frame_end), 32'd0);
        end
        @(posedge clk);
        #1;

        // Frame 1: flat 0x10 box
        for (int i = 0; i < W * H; i++) beat({9{8'h10}}, 1'b0, 8'h10);
        idle(4);
        check("latency", 32'(t_out - t_in), 32'd3);

        // Frame 2: directed arithmetic and border cases
        bdr(8'h11, 1'b0, 1'b0);
        bdr(8'h22, 1'b1, 1'b0);
        bdr(8'hAB, 1'b0, 1'b0);
        bdr(8'h33, 1'b0, 1'b0);
        bdr(8'h44, 1'b1, 1'b0);
        beat(72'h090807060504030201, 1'b0, 8'd5);
        beat(72'h090807060504030201, 1'b1, 8'd5);
        bdr(8'h55, 1'b0, 1'b0);
        bdr(8'h66, 1'b1, 1'b0);
        beat(72'h010101010501010101, 1'b0, 8'd1);
        beat(72'h010101010601010101, 1'b0, 8'd2);
        bdr(8'h77, 1'b0, 1'b0);
        bdr(8'h88, 1'b1, 1'b0);
        bdr(8'h99, 1'b0, 1'b0);
        bdr(8'hAA, 1'b1, 1'b0);
        bdr(8'hBB, 1'b0, 1'b0);

        // Frame 3: saturation, Gaussian half-rounding, X on border neighbours
        bdr(8'hC0, 1'b0, 1'b1);
        bdr(8'hC1, 1'b1, 1'b1);
        bdr(8'hAB, 1'b1, 1'b1);
        bdr(8'hC3, 1'b0, 1'b1);
        bdr(8'hC4, 1'b1, 1'b1);
        beat({9{8'hFF}}, 1'b0, 8'hFF);
        beat({9{8'hFF}}, 1'b1, 8'hFF);
        bdr(8'hC7, 1'b0, 1'b1);
        bdr(8'hC8, 1'b1, 1'b1);
        beat(72'h000000000600000000, 1'b1, 8'd2);
        beat({9{8'h10}}, 1'b1, 8'h10);
        bdr(8'hCB, 1'b0, 1'b1);
        bdr(8'hCC, 1'b1, 1'b1);
        bdr(8'hCD, 1'b0, 1'b1);
        bdr(8'hCE, 1'b1, 1'b1);
        bdr(8'hCF, 1'b0, 1'b1);

        // Frame 4: mode toggling every beat with 2-cycle gaps
        for (int i = 0; i < W * H; i++) begin
            mbeat(gen_win(i), 1'(i));
            if (i % 3 == 2) idle(2);
        end

        // Mid-frame reset with beats still in flight
        for (int i = 0; i < 7; i++) mbeat(gen_win(100 + i), 1'(i));
        rst = 1'b1;
        q.delete();
        #1;
        check("reset_valid", 32'(bus.o_pixel_valid), 32'd0);
        check("reset_pixel", 32'(bus.o_pixel), 32'd0);
        check("reset_frame_end", 32'(bus.o_frame_end), 32'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        row_m = 0;
        col_m = 0;
        beat({32'h01020304, 8'h5A, 32'h05060708}, 1'b0, 8'h5A);
        for (int i = 1; i < 7; i++) mbeat(gen_win(200 + i), 1'(i));

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        check("drain", 32'(q.size()), 32'd0);
        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
